// File: rtl/branch_unit.sv
// Branch unit: holds the ALU status flags (Z, N, V) and the program counter,
// and resolves conditional branches through a four-state IDLE/EVAL/UPDATE/DONE sequence.
module branch_unit #(
    parameter int unsigned    PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      status_in,
    input  logic            loads,
    input  logic            pc_inc,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_cond,
    input  logic [7:0]      br_imm,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      status,
    output logic            br_done,
    output logic            br_taken,
    output logic            br_err
);

    localparam int unsigned COND_W = 3;
    localparam int unsigned IMM_W  = 8;

    localparam logic [COND_W-1:0] COND_B   = 3'd0;
    localparam logic [COND_W-1:0] COND_BEQ = 3'd1;
    localparam logic [COND_W-1:0] COND_BNE = 3'd2;
    localparam logic [COND_W-1:0] COND_BLT = 3'd3;
    localparam logic [COND_W-1:0] COND_BLE = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EVAL   = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [2:0]        status_q;
    logic [COND_W-1:0] cond_q;
    logic [IMM_W-1:0]  imm_q;
    logic              taken_q;
    logic              err_q;

    logic              taken_d;
    logic              err_d;
    logic [PC_W-1:0]   pc_step_d;
    logic [PC_W-1:0]   pc_branch_d;

    // Condition decode against the flags held before any same-edge load.
    always_comb begin
        taken_d = 1'b0;
        err_d   = 1'b0;
        unique case (cond_q)
            COND_B:   taken_d = 1'b1;
            COND_BEQ: taken_d = status_q[2];
            COND_BNE: taken_d = ~status_q[2];
            COND_BLT: taken_d = status_q[1] ^ status_q[0];
            COND_BLE: taken_d = (status_q[1] ^ status_q[0]) | status_q[2];
            default:  err_d   = 1'b1;
        endcase
    end

    // Sequential advance and branch target; both wrap modulo 2^PC_W.
    always_comb begin
        pc_step_d   = pc_q + PC_W'(1);
        pc_branch_d = pc_step_d + PC_W'($signed(imm_q));
    end

    // Status register: loads wins in every FSM state, nothing else writes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q <= 3'b000;
        end else if (loads) begin
            status_q <= status_in;
        end
    end

    // Branch FSM with program counter and captured branch operands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cond_q  <= '0;
            imm_q   <= '0;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (br_valid) begin
                        cond_q  <= br_cond;
                        imm_q   <= br_imm;
                        state_q <= S_EVAL;
                    end else if (pc_inc) begin
                        pc_q <= pc_step_d;
                    end
                end
                S_EVAL: begin
                    taken_q <= taken_d;
                    err_q   <= err_d;
                    state_q <= S_UPDATE;
                end
                S_UPDATE: begin
                    pc_q    <= taken_q ? pc_branch_d : pc_step_d;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake and result outputs come straight from registered state.
    always_comb begin
        br_ready = (state_q == S_IDLE);
        br_done  = (state_q == S_DONE);
        br_taken = (state_q == S_DONE) & taken_q;
        br_err   = (state_q == S_DONE) & err_q;
        pc       = pc_q;
        status   = status_q;
    end

endmodule
